dram_cmd_sched: RTL and testbench

DRAM_CMD_SCHED -- requirements
Module: dram_cmd_sched

---
 rtl/dram_pkg.sv | 48 ++++
 rtl/dram_timer.sv | 23 ++
 rtl/dram_cmd_sched.sv | 157 +++++++++++++++
 tb/tb_dram_cmd_sched.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared types and address-field layout for the DRAM command scheduler.
// The command encoding is visible on the cmd port, so its values are fixed.
package dram_pkg;

  typedef enum logic [2:0] {
    NOP = 3'd0,
    ACT = 3'd1,
    RD  = 3'd2,
    WR  = 3'd3,
    PRE = 3'd4,
    REF = 3'd5
  } dram_cmd_t;

  typedef enum logic [3:0] {
    POWER_UP  = 4'd0,
    IDLE      = 4'd1,
    ACTIVATE  = 4'd2,
    ACT_WAIT  = 4'd3,
    READ      = 4'd4,
    RD_WAIT   = 4'd5,
    WRITE     = 4'd6,
    WR_WAIT   = 4'd7,
    PRECHARGE = 4'd8,
    PRE_WAIT  = 4'd9,
    REFRESH   = 4'd10,
    REF_WAIT  = 4'd11
  } dram_state_t;

  localparam int BANK_W   = 2;
  localparam int ROW_W    = 15;
  localparam int COL_W    = 10;
  localparam int BANK_OFF = 12;
  localparam int ROW_OFF  = 14;
  localparam int COL_OFF  = 2;

  // Command driven during the single cycle spent in a command state.
  function automatic dram_cmd_t state_cmd(input dram_state_t s);
    case (s)
      ACTIVATE:  return ACT;
      READ:      return RD;
      WRITE:     return WR;
      PRECHARGE: return PRE;
      REFRESH:   return REF;
      default:   return NOP;
    endcase
  endfunction

endpackage

// File: rtl/dram_timer.sv
// Down-counter shared by all wait phases: load the wait length, count to zero,
// and flag the last wait cycle.
module dram_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            cnt <= '0;
    else if (load)         cnt <= load_val;
    else if (cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign done = (cnt == W'(1));

endmodule

// File: rtl/dram_cmd_sched.sv
// Closed-page DRAM command scheduler: ACT / RD|WR / PRE per access, with
// periodic refresh served only from IDLE.
module dram_cmd_sched
  import dram_pkg::*;
#(
  parameter int unsigned tRCD  = 4,
  parameter int unsigned tCL   = 4,
  parameter int unsigned tWR   = 4,
  parameter int unsigned tRP   = 4,
  parameter int unsigned tRFC  = 16,
  parameter int unsigned tREFI = 200
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [31:0]       ram_addr,
  input  logic              init_done,
  output logic              init_req,
  output logic              ram_wait,
  output dram_cmd_t         cmd,
  output logic [BANK_W-1:0] bank,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col,
  output logic              tACT_done,
  output logic              tRD_done,
  output logic              tWR_done,
  output logic              tPRE_done,
  output logic              tREF_done,
  output logic              rf_req
);

  localparam int unsigned M1    = (tRCD > tCL) ? tRCD : tCL;
  localparam int unsigned M2    = (tWR > tRP) ? tWR : tRP;
  localparam int unsigned M3    = (M1 > M2) ? M1 : M2;
  localparam int unsigned T_MAX = (M3 > tRFC) ? M3 : tRFC;
  localparam int TW = $clog2(T_MAX) + 1;
  localparam int RW = $clog2(tREFI) + 1;

  // Loaded values are wait-cycle counts: the command cycle itself is not counted.
  localparam logic [TW-1:0] L_RCD = TW'(tRCD - 1);
  localparam logic [TW-1:0] L_CL  = TW'(tCL - 1);
  localparam logic [TW-1:0] L_WR  = TW'(tWR - 1);
  localparam logic [TW-1:0] L_RP  = TW'(tRP - 1);
  localparam logic [TW-1:0] L_RFC = TW'(tRFC - 1);

  dram_state_t   state, nxt;
  logic          we;
  logic          tload, tdone;
  logic [TW-1:0] lval;
  logic [RW-1:0] rcnt;
  logic          rexp;
  logic          unused_addr;

  assign unused_addr = ^{ram_addr[31:29], ram_addr[1:0]};

  dram_timer #(.W(TW)) u_timer (
    .clk      (CLK),
    .rst_n    (nRST),
    .load     (tload),
    .load_val (lval),
    .done     (tdone)
  );

  always_comb begin
    nxt   = state;
    tload = 1'b0;
    lval  = '0;
    case (state)
      POWER_UP: if (init_done) nxt = IDLE;
      IDLE: begin
        if (rf_req)            nxt = REFRESH;
        else if (dREN || dWEN) nxt = ACTIVATE;
      end
      ACTIVATE: begin
        tload = 1'b1;
        lval  = L_RCD;
        if (tRCD > 1) nxt = ACT_WAIT;
        else          nxt = we ? WRITE : READ;
      end
      ACT_WAIT: if (tdone) nxt = we ? WRITE : READ;
      READ: begin
        tload = 1'b1;
        lval  = L_CL;
        nxt   = (tCL > 1) ? RD_WAIT : PRECHARGE;
      end
      RD_WAIT: if (tdone) nxt = PRECHARGE;
      WRITE: begin
        tload = 1'b1;
        lval  = L_WR;
        nxt   = (tWR > 1) ? WR_WAIT : PRECHARGE;
      end
      WR_WAIT: if (tdone) nxt = PRECHARGE;
      PRECHARGE: begin
        tload = 1'b1;
        lval  = L_RP;
        nxt   = (tRP > 1) ? PRE_WAIT : IDLE;
      end
      PRE_WAIT: if (tdone) nxt = IDLE;
      REFRESH: begin
        tload = 1'b1;
        lval  = L_RFC;
        nxt   = (tRFC > 1) ? REF_WAIT : IDLE;
      end
      REF_WAIT: if (tdone) nxt = IDLE;
      default:  nxt = POWER_UP;
    endcase
  end

  // Outputs are registered from the next state so cmd lines up with its state.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= POWER_UP;
      cmd      <= NOP;
      ram_wait <= 1'b1;
      init_req <= 1'b1;
      we       <= 1'b0;
      bank     <= '0;
      row      <= '0;
      col      <= '0;
    end else begin
      state    <= nxt;
      cmd      <= state_cmd(nxt);
      ram_wait <= (nxt != PRECHARGE);
      init_req <= (nxt == POWER_UP);
      if (state == IDLE && nxt == ACTIVATE) begin
        we   <= dWEN;
        bank <= ram_addr[BANK_OFF +: BANK_W];
        row  <= ram_addr[ROW_OFF +: ROW_W];
        col  <= ram_addr[COL_OFF +: COL_W];
      end
    end
  end

  assign rexp = (rcnt == RW'(tREFI - 1));

  // A fresh expiry wins over the clear, so at most one refresh is ever owed.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rcnt   <= '0;
      rf_req <= 1'b0;
    end else if (state == POWER_UP) begin
      rcnt   <= '0;
    end else begin
      rcnt <= rexp ? '0 : rcnt + 1'b1;
      if (rexp)                                rf_req <= 1'b1;
      else if (state == IDLE && nxt == REFRESH) rf_req <= 1'b0;
    end
  end

  assign tACT_done = tdone && (state == ACT_WAIT);
  assign tRD_done  = tdone && (state == RD_WAIT);
  assign tWR_done  = tdone && (state == WR_WAIT);
  assign tPRE_done = tdone && (state == PRE_WAIT);
  assign tREF_done = tdone && (state == REF_WAIT);

endmodule

// File: tb/tb_dram_cmd_sched.sv
// Directed bench for dram_cmd_sched at default timing; cycle numbers count
// negedges from reset release.
module tb_dram_cmd_sched;
  import dram_pkg::*;

  logic        CLK, nRST, dREN, dWEN, init_done;
  logic [31:0] ram_addr;
  logic        init_req, ram_wait, rf_req;
  dram_cmd_t   cmd;
  logic [1:0]  bank;
  logic [14:0] row;
  logic [9:0]  col;
  logic        tACT_done, tRD_done, tWR_done, tPRE_done, tREF_done;
  logic [4:0]  dn;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic bad;

  assign dn = {tACT_done, tRD_done, tWR_done, tPRE_done, tREF_done};

  dram_cmd_sched dut (
    .CLK(CLK), .nRST(nRST), .dREN(dREN), .dWEN(dWEN), .ram_addr(ram_addr),
    .init_done(init_done), .init_req(init_req), .ram_wait(ram_wait), .cmd(cmd),
    .bank(bank), .row(row), .col(col), .tACT_done(tACT_done), .tRD_done(tRD_done),
    .tWR_done(tWR_done), .tPRE_done(tPRE_done), .tREF_done(tREF_done), .rf_req(rf_req)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        dren, dwen;
    logic [31:0] addr;
    logic [2:0]  cmd;
    logic        rw;
    logic [4:0]  dn;
    logic [1:0]  bank;
    logic [14:0] row;
    logic [9:0]  col;
  } vec_t;

  vec_t tbl [27];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge CLK);
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) begin
      if (cmd !== NOP) bad = 1'b1;
      step();
    end
  endtask

  initial begin
    // Read at T=228 (i=0), then write (dREN+dWEN) at T+13; addresses change in flight.
    for (int i = 0; i < 27; i++) begin
      tbl[i].dren = 1'b0;
      tbl[i].dwen = 1'b0;
      tbl[i].addr = 32'h0;
      tbl[i].cmd  = 3'(NOP);
      tbl[i].rw   = 1'b1;
      tbl[i].dn   = 5'b0;
      if (i == 0)       begin tbl[i].bank = 2'd0; tbl[i].row = 15'd0; tbl[i].col = 10'd0; end
      else if (i <= 13) begin tbl[i].bank = 2'd3; tbl[i].row = 15'd0; tbl[i].col = 10'd1; end
      else              begin tbl[i].bank = 2'd0; tbl[i].row = 15'd1; tbl[i].col = 10'd0; end
      if (i <= 9) begin
        tbl[i].dren = 1'b1;
        tbl[i].addr = (i < 3) ? 32'h0000_3004 : 32'hFFFF_FFFF;
      end
      if (i >= 13 && i <= 15) begin
        tbl[i].dren = 1'b1;
        tbl[i].dwen = 1'b1;
        tbl[i].addr = 32'h0000_4000;
      end
      if (i >= 16 && i <= 22) begin
        tbl[i].dren = 1'b1;
        tbl[i].addr = 32'h0000_3004;
      end
    end
    tbl[1].cmd  = 3'(ACT);
    tbl[4].dn   = 5'b10000;
    tbl[5].cmd  = 3'(RD);
    tbl[8].dn   = 5'b01000;
    tbl[9].cmd  = 3'(PRE);  tbl[9].rw  = 1'b0;
    tbl[12].dn  = 5'b00010;
    tbl[14].cmd = 3'(ACT);
    tbl[17].dn  = 5'b10000;
    tbl[18].cmd = 3'(WR);
    tbl[21].dn  = 5'b00100;
    tbl[22].cmd = 3'(PRE);  tbl[22].rw = 1'b0;
    tbl[25].dn  = 5'b00010;

    nRST = 1'b1; dREN = 1'b0; dWEN = 1'b0; ram_addr = 32'h0; init_done = 1'b0;
    #2 nRST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst cmd", 32'(cmd), 32'(NOP));
    chk("rst ram_wait", 32'(ram_wait), 1);
    chk("rst init_req", 32'(init_req), 1);
    chk("rst rf_req", 32'(rf_req), 0);
    chk("rst done", 32'(dn), 0);
    chk("rst addr", {bank, row, col}, 0);

    nRST = 1'b1;
    cyc  = 0;
    bad  = 1'b0;
    while (cyc < 11) begin
      if (init_req !== 1'b1 || cmd !== NOP) bad = 1'b1;
      if (cyc == 10) init_done = 1'b1;
      step();
    end
    chk("powerup init_req/cmd", 32'(bad), 0);
    chk("init_req fall", 32'(init_req), 0);

    bad = 1'b0;
    while (cyc < 211) begin
      if (rf_req !== 1'b0 || cmd !== NOP) bad = 1'b1;
      step();
    end
    chk("idle before refresh", 32'(bad), 0);
    chk("rf_req set", 32'(rf_req), 1);
    step();
    chk("ref cmd", 32'(cmd), 32'(REF));
    chk("rf_req cleared", 32'(rf_req), 0);
    bad = 1'b0;
    step();
    run_to(226);
    chk("ref wait cmd", 32'(bad), 0);
    chk("ref done early", 32'(dn), 0);
    step();
    chk("ref done", 32'(dn), 32'(5'b00001));
    step();
    chk("ref done late", 32'(dn), 0);

    for (int i = 0; i < 27; i++) begin
      chk($sformatf("vec%0d cmd", i), 32'(cmd), 32'(tbl[i].cmd));
      chk($sformatf("vec%0d ram_wait", i), 32'(ram_wait), 32'(tbl[i].rw));
      chk($sformatf("vec%0d done", i), 32'(dn), 32'(tbl[i].dn));
      chk($sformatf("vec%0d addr", i), {bank, row, col}, {tbl[i].bank, tbl[i].row, tbl[i].col});
      dREN     = tbl[i].dren;
      dWEN     = tbl[i].dwen;
      ram_addr = tbl[i].addr;
      step();
    end

    // Read at 405 so the second refresh interval expires in RD_WAIT (cycle 411).
    bad = 1'b0;
    run_to(405);
    chk("idle before read2", 32'(bad), 0);
    dREN = 1'b1; ram_addr = 32'h1000_2008;
    step();
    chk("read2 act", 32'(cmd), 32'(ACT));
    chk("read2 addr", {bank, row, col}, {2'd2, 15'h4000, 10'd2});
    run_to(410);
    chk("read2 rd", 32'(cmd), 32'(RD));
    step();
    chk("rf_req mid-access", 32'(rf_req), 1);
    chk("no preempt", 32'(cmd), 32'(NOP));
    run_to(414);
    chk("read2 pre", 32'(cmd), 32'(PRE));
    chk("read2 ram_wait", 32'(ram_wait), 0);
    dREN = 1'b0; ram_addr = 32'h0;
    step();
    run_to(418);
    chk("pre_wait rf_req", 32'(rf_req), 1);
    dWEN = 1'b1; ram_addr = 32'h1000_2008;
    step();
    chk("refresh beats request", 32'(cmd), 32'(REF));
    step();
    run_to(434);
    chk("ref2 done", 32'(dn), 32'(5'b00001));
    step();
    step();
    chk("held write act", 32'(cmd), 32'(ACT));
    run_to(440);
    chk("write wr", 32'(cmd), 32'(WR));
    step();
    step();

    // Asynchronous reset mid WR_WAIT, checked before any clock edge.
    nRST = 1'b0; dWEN = 1'b0; init_done = 1'b0;
    #1;
    chk("async rst cmd", 32'(cmd), 32'(NOP));
    chk("async rst ram_wait", 32'(ram_wait), 1);
    chk("async rst init_req", 32'(init_req), 1);
    chk("async rst addr", {bank, row, col}, 0);
    step();
    step();
    nRST = 1'b1;
    bad  = 1'b0;
    repeat (12) begin
      if (cmd !== NOP || init_req !== 1'b1 || ram_wait !== 1'b1) bad = 1'b1;
      step();
    end
    chk("post-reset no pre", 32'(bad), 0);
    init_done = 1'b1;
    step();
    step();
    chk("re-init init_req", 32'(init_req), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
